// File: rtl/mem_port_arbiter.sv
// Shares one single-ported synchronous memory between a fetch and a load/store requester.
// Data wins by default; fetch is forced through after MAX_DATA_STREAK consecutive data grants.
module mem_port_arbiter #(
  parameter int unsigned AW              = 32,
  parameter int unsigned DW              = 32,
  parameter int unsigned READ_LAT        = 1,
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic [3:0]    d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic [3:0]    mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          core_stall
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } tag_t;

  logic [3:0]    streak;
  tag_t          tag_q [READ_LAT];
  tag_t          tag_in;
  tag_t          tag_last;
  logic [DW-1:0] if_hold;
  logic [DW-1:0] d_hold;

  // Grants are suppressed during reset so every output reads as 0.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (!reset) begin
      if (if_req && (!d_req || streak == STREAK_MAX)) begin
        if_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    mem_en     = if_gnt | d_gnt;
    mem_we     = d_gnt ? d_we : '0;
    mem_wdata  = d_gnt ? d_wdata : '0;
    mem_addr   = '0;
    if (if_gnt) begin
      mem_addr = if_addr;
    end else if (d_gnt) begin
      mem_addr = d_addr;
    end
    core_stall = ~reset & ((if_req & ~if_gnt) | (d_req & ~d_gnt));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      streak <= '0;
    end else if (!if_req || if_gnt) begin
      streak <= '0;
    end else if (d_gnt && streak != STREAK_MAX) begin
      streak <= streak + 4'd1;
    end
  end

  always_comb begin
    tag_in.valid = if_gnt | (d_gnt & (d_we == 4'b0000));
    tag_in.owner = if_gnt ? OWN_FETCH : OWN_DATA;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < READ_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= tag_in;
      for (int unsigned i = 1; i < READ_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign tag_last = tag_q[READ_LAT-1];

  // Owner sees memory data live on its rvalid cycle; otherwise its last word is replayed.
  always_comb begin
    if_rvalid = ~reset & tag_last.valid & (tag_last.owner == OWN_FETCH);
    d_rvalid  = ~reset & tag_last.valid & (tag_last.owner == OWN_DATA);
    if_rdata  = '0;
    d_rdata   = '0;
    if (!reset) begin
      if_rdata = if_rvalid ? mem_rdata : if_hold;
      d_rdata  = d_rvalid ? mem_rdata : d_hold;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if_hold <= '0;
      d_hold  <= '0;
    end else begin
      if (if_rvalid) begin
        if_hold <= mem_rdata;
      end
      if (d_rvalid) begin
        d_hold <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Drives two arbiters (READ_LAT 1 and 2) with identical request vectors; grants checked
// against a table, read responses against a scoreboard fed from a reference memory.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        d_req = 1'b0;
  logic [3:0]  d_we = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;

  logic        if_gnt_a    [2];
  logic        if_rvalid_a [2];
  logic [31:0] if_rdata_a  [2];
  logic        d_gnt_a     [2];
  logic        d_rvalid_a  [2];
  logic [31:0] d_rdata_a   [2];
  logic        mem_en_a    [2];
  logic [3:0]  mem_we_a    [2];
  logic [31:0] mem_addr_a  [2];
  logic [31:0] mem_wdata_a [2];
  logic [31:0] mem_rdata_a [2];
  logic        core_stall_a[2];

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE_0000 | (32'(i) << 2);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    logic [31:0] mem [0:255];
    logic [31:0] p0;
    logic [31:0] p1;

    initial begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end

    always @(posedge clk) begin
      if (mem_en_a[g]) begin
        if (mem_we_a[g] != 4'b0000) begin
          for (int b = 0; b < 4; b++) begin
            if (mem_we_a[g][b]) mem[mem_addr_a[g][9:2]][8*b +: 8] <= mem_wdata_a[g][8*b +: 8];
          end
        end else begin
          p0 <= mem[mem_addr_a[g][9:2]];
        end
      end
      p1 <= p0;
    end

    assign mem_rdata_a[g] = (g == 0) ? p0 : p1;

    mem_port_arbiter #(
      .AW(32),
      .DW(32),
      .READ_LAT(g + 1),
      .MAX_DATA_STREAK(4)
    ) u_dut (
      .clk(clk),
      .reset(reset),
      .if_req(if_req),
      .if_addr(if_addr),
      .if_gnt(if_gnt_a[g]),
      .if_rvalid(if_rvalid_a[g]),
      .if_rdata(if_rdata_a[g]),
      .d_req(d_req),
      .d_we(d_we),
      .d_addr(d_addr),
      .d_wdata(d_wdata),
      .d_gnt(d_gnt_a[g]),
      .d_rvalid(d_rvalid_a[g]),
      .d_rdata(d_rdata_a[g]),
      .mem_en(mem_en_a[g]),
      .mem_we(mem_we_a[g]),
      .mem_addr(mem_addr_a[g]),
      .mem_wdata(mem_wdata_a[g]),
      .mem_rdata(mem_rdata_a[g]),
      .core_stall(core_stall_a[g])
    );
  end

  typedef struct {
    bit          rst;
    bit          ifr;
    logic [31:0] ifa;
    bit          dr;
    logic [3:0]  we;
    logic [31:0] da;
    logic [31:0] wd;
    bit          eif;
    bit          ed;
  } vec_t;

  typedef struct {
    int          inst;
    bit          owner;
    logic [31:0] data;
    int          due;
  } rsp_t;

  vec_t        tbl[$];
  rsp_t        sb[$];
  logic [31:0] ref_mem [0:255];
  logic [31:0] last_if [2];
  logic [31:0] last_d  [2];
  int          cyc = 0;
  int          n_pass = 0;
  int          n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    else n_pass++;
  endtask

  function automatic vec_t mk(input bit rst, input bit ifr, input logic [31:0] ifa,
                              input bit dr, input logic [3:0] we, input logic [31:0] da,
                              input logic [31:0] wd, input bit eif, input bit ed);
    vec_t v;
    v.rst = rst; v.ifr = ifr; v.ifa = ifa; v.dr = dr; v.we = we;
    v.da = da; v.wd = wd; v.eif = eif; v.ed = ed;
    return v;
  endfunction

  task automatic add(input vec_t v);
    tbl.push_back(v);
  endtask

  task automatic step(input vec_t v);
    @(posedge clk);
    #1;
    reset = v.rst; if_req = v.ifr; if_addr = v.ifa;
    d_req = v.dr; d_we = v.we; d_addr = v.da; d_wdata = v.wd;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      string       sfx;
      bit          xi;
      bit          xd;
      logic [31:0] xir;
      logic [31:0] xdr;
      sfx = $sformatf("[L%0d]", g + 1);
      chk({"if_gnt", sfx}, 32'(if_gnt_a[g]), 32'(v.eif));
      chk({"d_gnt", sfx}, 32'(d_gnt_a[g]), 32'(v.ed));
      chk({"core_stall", sfx}, 32'(core_stall_a[g]),
          v.rst ? 32'd0 : 32'((v.ifr & ~v.eif) | (v.dr & ~v.ed)));
      chk({"mem_en", sfx}, 32'(mem_en_a[g]), 32'(v.eif | v.ed));
      chk({"mem_we", sfx}, 32'(mem_we_a[g]), v.ed ? 32'(v.we) : 32'd0);
      if (v.rst) begin
        chk({"mem_addr_rst", sfx}, mem_addr_a[g], 32'd0);
        chk({"mem_wdata_rst", sfx}, mem_wdata_a[g], 32'd0);
      end else if (v.eif || v.ed) begin
        chk({"mem_addr", sfx}, mem_addr_a[g], v.eif ? v.ifa : v.da);
        if (v.ed && v.we != 4'b0000) chk({"mem_wdata", sfx}, mem_wdata_a[g], v.wd);
      end
      xi = 1'b0; xd = 1'b0;
      if (v.rst) begin
        xir = '0; xdr = '0;
      end else begin
        xir = last_if[g]; xdr = last_d[g];
        for (int i = 0; i < sb.size(); i++) begin
          if (sb[i].inst == g && sb[i].due == cyc) begin
            if (sb[i].owner) begin xd = 1'b1; xdr = sb[i].data; last_d[g] = xdr; end
            else begin xi = 1'b1; xir = sb[i].data; last_if[g] = xir; end
            sb.delete(i);
            break;
          end
        end
      end
      chk({"if_rvalid", sfx}, 32'(if_rvalid_a[g]), 32'(xi));
      chk({"d_rvalid", sfx}, 32'(d_rvalid_a[g]), 32'(xd));
      chk({"if_rdata", sfx}, if_rdata_a[g], xir);
      chk({"d_rdata", sfx}, d_rdata_a[g], xdr);
    end
    if (v.rst) begin
      sb.delete();
      for (int g = 0; g < 2; g++) begin last_if[g] = '0; last_d[g] = '0; end
    end else begin
      for (int g = 0; g < 2; g++) begin
        if (v.eif) sb.push_back('{inst: g, owner: 1'b0, data: ref_mem[v.ifa[9:2]], due: cyc + g + 1});
        if (v.ed && v.we == 4'b0000)
          sb.push_back('{inst: g, owner: 1'b1, data: ref_mem[v.da[9:2]], due: cyc + g + 1});
      end
      if (v.ed && v.we != 4'b0000) begin
        for (int b = 0; b < 4; b++) if (v.we[b]) ref_mem[v.da[9:2]][8*b +: 8] = v.wd[8*b +: 8];
      end
    end
    cyc++;
  endtask

  initial begin
    int dn;
    int fn;
    vec_t idle;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    for (int g = 0; g < 2; g++) begin last_if[g] = '0; last_d[g] = '0; end
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // reset state
    add(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    add(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    // fetch only, back-to-back
    add(mk(0, 1, 32'h0, 0, 0, 0, 0, 1, 0));
    add(mk(0, 1, 32'h4, 0, 0, 0, 0, 1, 0));
    add(mk(0, 1, 32'h8, 0, 0, 0, 0, 1, 0));
    add(idle); add(idle);
    // collision: data first, fetch next cycle
    add(mk(0, 1, 32'h40, 1, 0, 32'h100, 0, 0, 1));
    add(mk(0, 1, 32'h40, 0, 0, 0, 0, 1, 0));
    add(idle); add(idle);
    // both held 10 cycles: 4 data grants, 1 fetch grant, repeating
    dn = 0; fn = 0;
    for (int k = 0; k < 10; k++) begin
      if (k % 5 == 4) begin
        add(mk(0, 1, 32'h80 + 32'(4 * fn), 1, 0, 32'h200 + 32'(4 * dn), 0, 1, 0));
        fn++;
      end else begin
        add(mk(0, 1, 32'h80 + 32'(4 * fn), 1, 0, 32'h200 + 32'(4 * dn), 0, 0, 1));
        dn++;
      end
    end
    add(idle); add(idle);
    // partial store then read-back of the same word
    add(mk(0, 0, 0, 1, 4'b0011, 32'h20, 32'hAAAA5555, 0, 1));
    add(mk(0, 0, 0, 1, 0, 32'h20, 0, 0, 1));
    add(idle); add(idle);
    // streak clears while fetch is idle, so four fresh data grants precede the fetch
    add(mk(0, 1, 32'hC0, 1, 0, 32'h300, 0, 0, 1));
    add(mk(0, 1, 32'hC0, 1, 0, 32'h304, 0, 0, 1));
    add(mk(0, 0, 0, 1, 0, 32'h308, 0, 0, 1));
    for (int k = 0; k < 4; k++) add(mk(0, 1, 32'hC4, 1, 0, 32'h30C + 32'(4 * k), 0, 0, 1));
    add(mk(0, 1, 32'hC4, 1, 0, 32'h31C, 0, 1, 0));
    add(idle); add(idle);
    // alternating single-requester reads every cycle
    for (int k = 0; k < 3; k++) begin
      add(mk(0, 1, 32'h100 + 32'(4 * k), 0, 0, 0, 0, 1, 0));
      add(mk(0, 0, 0, 1, 0, 32'h180 + 32'(4 * k), 0, 0, 1));
    end
    add(idle); add(idle); add(idle);

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // reset one cycle after a read grant drops the response
    step(mk(0, 1, 32'h10, 0, 0, 0, 0, 1, 0));
    step(mk(1, 1, 32'h14, 1, 0, 32'h50, 0, 0, 0));
    step(mk(0, 1, 32'h14, 1, 0, 32'h50, 0, 0, 1));
    step(mk(0, 1, 32'h14, 0, 0, 0, 0, 1, 0));
    step(idle); step(idle); step(idle);

    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
